// File: rtl/dff_rr_arb_pkg.sv
// dff_rr_arb_pkg: shared types, default sizes and pointer helper for the round-robin slot arbiter
package dff_rr_arb_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 32;
  localparam int IDW_DEF = (N_DEF > 1) ? $clog2(N_DEF) : 1;
  typedef logic [IDW_DEF-1:0] id_t;
  typedef enum logic {ARB, LOCKED} state_e;
  function automatic int unsigned ptr_inc(input int unsigned w, input int unsigned n);
    return (w == n - 1) ? 0 : w + 1;
  endfunction
endpackage

// File: rtl/dff.sv
// dff: plain register with asynchronous active-low clear
//   clk, arst_n : clock and reset
//   d, q        : WIDTH-bit data in/out
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) q <= '0;
    else q <= d;
endmodule

// File: rtl/dff_rr_arb_rr_pick.sv
// rr_pick: combinational round-robin pick, first request at or after ptr
//   req  : N-bit request vector
//   ptr  : search start index
//   gnt  : one-hot winner, idx : encoded winner, any : some request present
module rr_pick #(
  parameter int N = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);
  logic [2*N-1:0] dbl;
  logic found;
  int s;
  // Searching a doubled copy from ptr upward covers the wrap without a modulo per bit.
  always_comb begin
    dbl = {req, req};
    found = 1'b0;
    s = 0;
    idx = '0;
    for (int k = 0; k < N; k++)
      if (!found && dbl[int'(ptr) + k]) begin
        found = 1'b1;
        s = int'(ptr) + k;
        s = (s >= N) ? s - N : s;
        idx = IDW'(s);
      end
    any = |req;
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/dff_rr_arb.sv
// dff_rr_arb: round-robin arbiter with packet lock feeding one registered valid/ready slot
//   clk, arst_n                : clock, asynchronous active-low reset
//   in_vld/in_data/in_last     : N requester beats (requester i at in_data[i*W +: W])
//   in_rdy                     : per-requester accept, one-hot or zero
//   out_vld/out_data/out_last  : registered output beat
//   out_id                     : requester that supplied the beat
//   out_rdy                    : downstream accept
module dff_rr_arb
  import dff_rr_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [N-1:0]   in_vld,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_rdy,
  output logic           out_vld,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [IDW-1:0] out_id,
  input  logic           out_rdy
);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, lk_q, lk_d, pick_idx, win;
  logic [N-1:0] pick_gnt, grant, rdy;
  logic pick_any, cap_en, xfer, win_last, vld_q, vld_d;
  logic [W-1:0] win_data;
  logic [W+IDW:0] pay_d, pay_q;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req(in_vld),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    cap_en = !vld_q || out_rdy;
    win = (state_q == LOCKED) ? lk_q : pick_idx;
    grant = (state_q == LOCKED) ? (in_vld[lk_q] ? (N'(1) << lk_q) : '0)
                                : (pick_any ? pick_gnt : '0);
    rdy = cap_en ? grant : '0;
    xfer = |(in_vld & rdy);
    win_data = in_data[int'(win)*W +: W];
    win_last = in_last[win];
    pay_d = xfer ? {win_last, win, win_data} : pay_q;
    // A fresh capture wins over draining, so back-to-back beats leave no bubble.
    vld_d = xfer || (vld_q && !out_rdy);
    state_d = state_q;
    lk_d = lk_q;
    ptr_d = ptr_q;
    if (xfer && win_last) begin
      state_d = ARB;
      ptr_d = IDW'(ptr_inc(32'(win), N));
    end else if (xfer && state_q == ARB) begin
      state_d = LOCKED;
      lk_d = win;
    end
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q <= ARB;
      ptr_q <= '0;
      lk_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lk_q <= lk_d;
      vld_q <= vld_d;
    end

  dff #(.WIDTH(W + IDW + 1)) u_pay (
    .clk(clk),
    .arst_n(arst_n),
    .d(pay_d),
    .q(pay_q)
  );

  // Reset holds every requester off even though the arbiter itself is combinational.
  assign in_rdy = rdy & {N{arst_n}};
  assign out_vld = vld_q;
  assign {out_last, out_id, out_data} = pay_q;
endmodule

// File: tb/tb_dff_rr_arb.sv
// tb_dff_rr_arb: directed self-checking bench for dff_rr_arb with N=4, W=32
module tb_dff_rr_arb;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [N-1:0] in_vld = '0, in_last = '0, in_rdy;
  logic [W-1:0] dat [N];
  logic [N*W-1:0] in_data;
  logic out_vld, out_last;
  logic out_rdy = 1'b0;
  logic [W-1:0] out_data;
  logic [IDW-1:0] out_id;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  dff_rr_arb #(.N(N), .W(W)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .in_vld(in_vld),
    .in_data(in_data),
    .in_last(in_last),
    .in_rdy(in_rdy),
    .out_vld(out_vld),
    .out_data(out_data),
    .out_last(out_last),
    .out_id(out_id),
    .out_rdy(out_rdy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Check in_rdy for the current inputs, clock once, then check the registered output.
  task automatic beat(input string tag, input logic [N-1:0] e_rdy, input logic e_vld,
                      input logic [IDW-1:0] e_id, input logic [W-1:0] e_data, input logic e_last);
    #1;
    check({tag, "_rdy"}, 64'(in_rdy), 64'(e_rdy));
    step();
    check({tag, "_vld"}, 64'(out_vld), 64'(e_vld));
    if (e_vld) begin
      check({tag, "_id"}, 64'(out_id), 64'(e_id));
      check({tag, "_data"}, 64'(out_data), 64'(e_data));
      check({tag, "_last"}, 64'(out_last), 64'(e_last));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) dat[i] = 32'hD000_0000 + 32'(i);
    in_vld = 4'b1111;
    in_last = 4'b1111;
    out_rdy = 1'b1;
    #2;
    check("rst_vld", 64'(out_vld), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_id", 64'(out_id), 64'd0);
    check("rst_rdy", 64'(in_rdy), 64'd0);
    step();
    step();
    arst_n = 1'b1;
    // Rotation with single-beat packets: ids 0,1,2,3,0.
    for (int k = 0; k < 5; k++)
      beat("rot", N'(1) << (k % N), 1'b1, IDW'(k % N), dat[k % N], 1'b1);
    // Requester 2 locks for three beats while 0 and 3 wait.
    in_vld = 4'b1101;
    in_last = 4'b1001;
    dat[2] = 32'hB200_0001;
    beat("pkt_b1", 4'b0100, 1'b1, 2, 32'hB200_0001, 1'b0);
    dat[2] = 32'hB200_0002;
    beat("pkt_b2", 4'b0100, 1'b1, 2, 32'hB200_0002, 1'b0);
    dat[2] = 32'hB200_0003;
    in_last = 4'b1101;
    beat("pkt_b3", 4'b0100, 1'b1, 2, 32'hB200_0003, 1'b1);
    in_vld = 4'b1001;
    beat("pkt_nx3", 4'b1000, 1'b1, 3, dat[3], 1'b1);
    beat("pkt_nx0", 4'b0001, 1'b1, 0, dat[0], 1'b1);
    // Backpressure holds the slot and blocks new grants.
    in_vld = 4'b0010;
    in_last = 4'b0010;
    dat[1] = 32'hA5A5_0001;
    beat("bp_load", 4'b0010, 1'b1, 1, 32'hA5A5_0001, 1'b1);
    out_rdy = 1'b0;
    dat[1] = 32'hA5A5_0002;
    for (int k = 0; k < 3; k++) beat("bp_hold", 4'b0000, 1'b1, 1, 32'hA5A5_0001, 1'b1);
    out_rdy = 1'b1;
    beat("bp_go", 4'b0010, 1'b1, 1, 32'hA5A5_0002, 1'b1);
    // Locked requester 1 goes idle mid-packet; requester 0 must stay blocked.
    in_last = 4'b0000;
    dat[1] = 32'hC100_0001;
    beat("gap_b1", 4'b0010, 1'b1, 1, 32'hC100_0001, 1'b0);
    in_vld = 4'b0001;
    in_last = 4'b0001;
    beat("gap_idle1", 4'b0000, 1'b0, 0, 0, 1'b0);
    beat("gap_idle2", 4'b0000, 1'b0, 0, 0, 1'b0);
    in_vld = 4'b0011;
    in_last = 4'b0011;
    dat[1] = 32'hC100_0002;
    beat("gap_end", 4'b0010, 1'b1, 1, 32'hC100_0002, 1'b1);
    in_vld = 4'b0101;
    in_last = 4'b0101;
    beat("gap_next", 4'b0100, 1'b1, 2, dat[2], 1'b1);
    // Reset while LOCKED(3) with a beat in the slot.
    in_vld = 4'b1000;
    in_last = 4'b0000;
    beat("rl_lock", 4'b1000, 1'b1, 3, dat[3], 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    check("rl_vld", 64'(out_vld), 64'd0);
    check("rl_id", 64'(out_id), 64'd0);
    check("rl_rdy", 64'(in_rdy), 64'd0);
    step();
    arst_n = 1'b1;
    in_vld = 4'b1001;
    in_last = 4'b1001;
    #1;
    check("rl_ptr0", 64'(in_rdy), 64'b0001);
    in_vld = 4'b1000;
    beat("rl_first", 4'b1000, 1'b1, 3, dat[3], 1'b1);
    // Idle stretch: slot drains after one cycle, pointer stays put.
    in_vld = 4'b0000;
    for (int k = 0; k < 5; k++) beat("idle", 4'b0000, 1'b0, 0, 0, 1'b0);
    in_vld = 4'b1001;
    #1;
    check("idle_ptr", 64'(in_rdy), 64'b0001);
    in_vld = 4'b0001;
    in_last = 4'b0001;
    beat("idle_wake", 4'b0001, 1'b1, 0, dat[0], 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
